// File: rtl/toggle_rate_sweep_ctrl_if.sv
// Run-control bundle between the sweep controller and its user/daisy chain.
// Handshake: start is a level sampled only while idle; abort is a level sampled
// every cycle; activity_valid and done are single-cycle strobes with no ready,
// so the consumer must capture them on the cycle they are high.
interface toggle_rate_sweep_ctrl_if;
  logic        start;
  logic        abort;
  logic        ram_o;
  logic        chain_rst;
  logic [6:0]  toggle_rate;
  logic        busy;
  logic [7:0]  step_idx;
  logic        activity_valid;
  logic [15:0] activity_cnt;
  logic        done;
  logic [2:0]  state_dbg;

  modport slave (
    input  start, abort, ram_o,
    output chain_rst, toggle_rate, busy, step_idx,
           activity_valid, activity_cnt, done, state_dbg
  );

  modport master (
    output start, abort, ram_o,
    input  chain_rst, toggle_rate, busy, step_idx,
           activity_valid, activity_cnt, done, state_dbg
  );
endinterface

// File: rtl/toggle_rate_sweep_ctrl.sv
// Sweeps the BRAM daisy chain through a programmed set of toggle rates.
// Each step: hold chain reset, let the pipeline fill, dwell while counting
// ram_o transitions, then emit a one-cycle report tagged with rate and index.
module toggle_rate_sweep_ctrl #(
  parameter int RATE_MIN      = 0,
  parameter int RATE_MAX      = 100,
  parameter int RATE_STEP     = 10,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 128,
  parameter int DWELL_CYCLES  = 1000000
) (
  input  logic                      clk,
  input  logic                      irst_n,
  toggle_rate_sweep_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETTLE = 3'd2,
    S_DWELL  = 3'd3,
    S_REPORT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  generate
    if (RATE_MAX > 100 || RATE_MIN < 0 || RATE_MIN > RATE_MAX || RATE_STEP <= 0 ||
        RST_CYCLES <= 0 || SETTLE_CYCLES <= 0 || DWELL_CYCLES <= 0 ||
        DWELL_CYCLES > 24'hFFFFFF) begin : g_bad_params
      $error("toggle_rate_sweep_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [1:0]  rst_sync_q;
  logic        rst_n_int;
  state_t      state_q, state_d;
  logic [31:0] cyc_q, cyc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  rate_q, rate_d;
  logic [7:0]  step_q, step_d;
  logic        ram_o_q;
  logic        chain_rst_q, busy_q, valid_q, done_q;
  logic [15:0] act_cnt_q;
  logic [7:0]  nxt_rate;

  // Reset asserts immediately, releases two clocks after irst_n rises.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // 8-bit sum so a rate near 100 plus the step cannot wrap back into range.
  assign nxt_rate = {1'b0, rate_q} + 8'(RATE_STEP);

  // Next-state, phase counter, transition counter and rate/index updates.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        cyc_d  = 32'd0;
        rate_d = 7'd0;
        if (bus.start && !bus.abort) begin
          state_d = S_RESET;
          rate_d  = 7'(RATE_MIN);
          step_d  = 8'd0;
        end
      end
      S_RESET: begin
        if (cyc_q == 32'(RST_CYCLES - 1)) begin
          state_d = S_SETTLE;
          cyc_d   = 32'd0;
          cnt_d   = 16'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_SETTLE: begin
        if (cyc_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d = S_DWELL;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_DWELL: begin
        if (bus.ram_o != ram_o_q && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (cyc_q == 32'(DWELL_CYCLES - 1)) begin
          state_d = S_REPORT;
          cyc_d   = 32'd0;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      S_REPORT: begin
        if (nxt_rate > 8'(RATE_MAX)) begin
          state_d = S_DONE;
          rate_d  = 7'd0;
        end else begin
          state_d = S_RESET;
          rate_d  = nxt_rate[6:0];
          step_d  = step_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rate_d  = 7'd0;
      end
      default: begin
        state_d = S_IDLE;
        rate_d  = 7'd0;
      end
    endcase
    // Abort overrides every transition, including the final REPORT->DONE.
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      rate_d  = 7'd0;
      cyc_d   = 32'd0;
    end
  end

  // State and datapath registers; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q     <= S_IDLE;
      cyc_q       <= 32'd0;
      cnt_q       <= 16'd0;
      rate_q      <= 7'd0;
      step_q      <= 8'd0;
      ram_o_q     <= 1'b0;
      chain_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      act_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      step_q      <= step_d;
      ram_o_q     <= bus.ram_o;
      chain_rst_q <= (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_DONE);
      busy_q      <= (state_d == S_RESET) || (state_d == S_SETTLE) ||
                     (state_d == S_DWELL) || (state_d == S_REPORT);
      valid_q     <= (state_d == S_REPORT);
      done_q      <= (state_d == S_DONE);
      if (state_d == S_REPORT) act_cnt_q <= cnt_d;
    end
  end

  assign bus.chain_rst      = chain_rst_q;
  assign bus.toggle_rate    = rate_q;
  assign bus.busy           = busy_q;
  assign bus.step_idx       = step_q;
  assign bus.activity_valid = valid_q;
  assign bus.activity_cnt   = act_cnt_q;
  assign bus.done           = done_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_toggle_rate_sweep_ctrl.sv
// Directed bench for toggle_rate_sweep_ctrl: three instances cover the
// 0/50/100 sweep with abort and reset, the single-step 95 sweep, and
// counter saturation over a long dwell.
module tb_toggle_rate_sweep_ctrl;

  logic clk;
  logic irst_n;
  int   n_tests;
  int   n_fail;
  logic tog_a;
  logic tog_c;

  toggle_rate_sweep_ctrl_if if_a ();
  toggle_rate_sweep_ctrl_if if_b ();
  toggle_rate_sweep_ctrl_if if_c ();

  toggle_rate_sweep_ctrl #(
    .RATE_MIN(0), .RATE_MAX(100), .RATE_STEP(50),
    .RST_CYCLES(2), .SETTLE_CYCLES(4), .DWELL_CYCLES(16)
  ) u_a (.clk(clk), .irst_n(irst_n), .bus(if_a));

  toggle_rate_sweep_ctrl #(
    .RATE_MIN(95), .RATE_MAX(100), .RATE_STEP(10),
    .RST_CYCLES(2), .SETTLE_CYCLES(4), .DWELL_CYCLES(16)
  ) u_b (.clk(clk), .irst_n(irst_n), .bus(if_b));

  toggle_rate_sweep_ctrl #(
    .RATE_MIN(0), .RATE_MAX(0), .RATE_STEP(1),
    .RST_CYCLES(1), .SETTLE_CYCLES(1), .DWELL_CYCLES(70000)
  ) u_c (.clk(clk), .irst_n(irst_n), .bus(if_c));

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_a) if_a.ram_o = ~if_a.ram_o;
    if (tog_c) if_c.ram_o = ~if_c.ram_o;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // One full 0/50/100 sweep on instance A with every report carrying exp_cnt.
  task automatic sweep_a(input logic [15:0] exp_cnt);
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    chk("a_start_busy", 32'(if_a.busy), 32'd1);
    chk("a_start_rst", 32'(if_a.chain_rst), 32'd1);
    chk("a_start_state", 32'(if_a.state_dbg), 32'd1);
    for (int s = 0; s < 3; s++) begin
      repeat (s == 0 ? 21 : 22) tick();
      chk("a_pre_report_valid", 32'(if_a.activity_valid), 32'd0);
      tick();
      chk("a_report_valid", 32'(if_a.activity_valid), 32'd1);
      chk("a_report_rate", 32'(if_a.toggle_rate), 32'(s * 50));
      chk("a_report_step", 32'(if_a.step_idx), 32'(s));
      chk("a_report_cnt", 32'(if_a.activity_cnt), 32'(exp_cnt));
      chk("a_report_chain_rst", 32'(if_a.chain_rst), 32'd0);
      chk("a_report_busy", 32'(if_a.busy), 32'd1);
    end
    tick();
    chk("a_done", 32'(if_a.done), 32'd1);
    chk("a_done_busy", 32'(if_a.busy), 32'd0);
    chk("a_done_rst", 32'(if_a.chain_rst), 32'd1);
    chk("a_done_rate", 32'(if_a.toggle_rate), 32'd0);
    chk("a_done_valid", 32'(if_a.activity_valid), 32'd0);
    tick();
    chk("a_after_done", 32'(if_a.done), 32'd0);
    chk("a_after_state", 32'(if_a.state_dbg), 32'd0);
  endtask

  initial begin
    int hits;
    int cyc;
    logic seen;
    logic [6:0] max_rate;
    n_tests = 0;
    n_fail  = 0;
    tog_a   = 1'b0;
    tog_c   = 1'b0;
    irst_n  = 1'b0;
    if_a.start = 1'b0; if_a.abort = 1'b0; if_a.ram_o = 1'b0;
    if_b.start = 1'b0; if_b.abort = 1'b0; if_b.ram_o = 1'b0;
    if_c.start = 1'b0; if_c.abort = 1'b0; if_c.ram_o = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_chain_rst", 32'(if_a.chain_rst), 32'd1);
    chk("rst_rate", 32'(if_a.toggle_rate), 32'd0);
    chk("rst_busy", 32'(if_a.busy), 32'd0);
    chk("rst_step", 32'(if_a.step_idx), 32'd0);
    chk("rst_valid", 32'(if_a.activity_valid), 32'd0);
    chk("rst_cnt", 32'(if_a.activity_cnt), 32'd0);
    chk("rst_done", 32'(if_a.done), 32'd0);
    chk("rst_state", 32'(if_a.state_dbg), 32'd0);
    irst_n = 1'b1;
    repeat (3) tick();

    // Full sweep with ram_o toggling every cycle: 16 transitions per dwell
    tog_a = 1'b1;
    sweep_a(16'd16);

    // Abort in the 3rd DWELL cycle of step 1
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (22) tick();
    chk("ab_report0_cnt", 32'(if_a.activity_cnt), 32'd16);
    repeat (9) tick();
    chk("ab_in_dwell", 32'(if_a.state_dbg), 32'd3);
    chk("ab_dwell_step", 32'(if_a.step_idx), 32'd1);
    if_a.abort = 1'b1;
    tick();
    if_a.abort = 1'b0;
    chk("ab_state", 32'(if_a.state_dbg), 32'd0);
    chk("ab_chain_rst", 32'(if_a.chain_rst), 32'd1);
    chk("ab_rate", 32'(if_a.toggle_rate), 32'd0);
    chk("ab_busy", 32'(if_a.busy), 32'd0);
    chk("ab_done", 32'(if_a.done), 32'd0);
    chk("ab_cnt_kept", 32'(if_a.activity_cnt), 32'd16);
    hits = 0;
    repeat (30) begin
      tick();
      if (if_a.activity_valid || if_a.done || if_a.busy) hits++;
    end
    chk("ab_quiet", 32'(hits), 32'd0);

    // Restart after abort with ram_o constant: begins at step 0, counts 0
    tog_a = 1'b0;
    sweep_a(16'd0);

    // start and abort together in IDLE: stay idle
    if_a.start = 1'b1;
    if_a.abort = 1'b1;
    tick();
    if_a.start = 1'b0;
    if_a.abort = 1'b0;
    chk("sa_idle_state", 32'(if_a.state_dbg), 32'd0);
    chk("sa_idle_busy", 32'(if_a.busy), 32'd0);

    // irst_n pulsed low mid-SETTLE of step 1
    if_a.start = 1'b1;
    tick();
    if_a.start = 1'b0;
    repeat (26) tick();
    chk("ir_pre_state", 32'(if_a.state_dbg), 32'd2);
    chk("ir_pre_rate", 32'(if_a.toggle_rate), 32'd50);
    chk("ir_pre_chain_rst", 32'(if_a.chain_rst), 32'd0);
    #2;
    irst_n = 1'b0;
    if_a.start = 1'b1;
    #1;
    chk("ir_async_chain_rst", 32'(if_a.chain_rst), 32'd1);
    chk("ir_async_rate", 32'(if_a.toggle_rate), 32'd0);
    chk("ir_async_busy", 32'(if_a.busy), 32'd0);
    chk("ir_async_step", 32'(if_a.step_idx), 32'd0);
    tick(); tick();
    #3;
    irst_n = 1'b1;
    tick();
    chk("ir_rel1_busy", 32'(if_a.busy), 32'd0);
    tick();
    chk("ir_rel2_busy", 32'(if_a.busy), 32'd0);
    tick();
    chk("ir_rel3_busy", 32'(if_a.busy), 32'd1);
    chk("ir_rel3_rate", 32'(if_a.toggle_rate), 32'd0);
    if_a.start = 1'b0;
    if_a.abort = 1'b1;
    tick();
    if_a.abort = 1'b0;
    chk("ir_abort_state", 32'(if_a.state_dbg), 32'd0);

    // Single-step sweep at rate 95; 95+10=105 ends the sweep
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    max_rate = 7'd0;
    hits = 0;
    repeat (22) begin
      tick();
      if (if_b.toggle_rate > max_rate) max_rate = if_b.toggle_rate;
      if (if_b.activity_valid) hits++;
    end
    chk("b_report_valid", 32'(if_b.activity_valid), 32'd1);
    chk("b_report_rate", 32'(if_b.toggle_rate), 32'd95);
    chk("b_report_step", 32'(if_b.step_idx), 32'd0);
    tick();
    chk("b_done", 32'(if_b.done), 32'd1);
    chk("b_done_rate", 32'(if_b.toggle_rate), 32'd0);
    chk("b_done_busy", 32'(if_b.busy), 32'd0);
    repeat (5) begin
      tick();
      if (if_b.toggle_rate > max_rate) max_rate = if_b.toggle_rate;
      if (if_b.activity_valid) hits++;
    end
    chk("b_max_rate", 32'(max_rate), 32'd95);
    chk("b_report_count", 32'(hits), 32'd1);

    // Long dwell with ram_o toggling: counter saturates at FFFF
    tog_c = 1'b1;
    if_c.start = 1'b1;
    tick();
    if_c.start = 1'b0;
    seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 70010 && !seen; i++) begin
      tick();
      cyc++;
      if (if_c.activity_valid) seen = 1'b1;
    end
    chk("c_report_seen", 32'(seen), 32'd1);
    chk("c_latency", 32'(cyc), 32'd70002);
    chk("c_sat_cnt", 32'(if_c.activity_cnt), 32'h0000FFFF);
    tick();
    chk("c_done", 32'(if_c.done), 32'd1);
    chk("c_cnt_hold", 32'(if_c.activity_cnt), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
